// File: rtl/trig_level_cursor.sv
// trig_level_cursor
//   Converts the on-screen trigger cursor row (8-bit screen level domain)
//   back into a 14-bit ADC trigger threshold for the current vertical
//   scale. The cursor is moved with up/down buttons (with auto-repeat),
//   the cursor-line pixel is produced for the VGA generator, and the
//   threshold is handed to the trigger unit over a valid/ready handshake.
//
//   Optional build macro: TRIG_MIDBIN_EN
//     defined   -> threshold sits mid-bin (adds 1 << (6 + shift))
//     undefined -> threshold is the lower bin edge
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   shift        vertical scale select 0..3
//   btn_up       debounced level, held = increment row
//   btn_down     debounced level, held = decrement row
//   scan_row     screen level of the pixel being drawn
//   scan_active  visible-pixel flag
//   cursor_row   current cursor row
//   cursor_pix   cursor-line pixel (registered)
//   trig_level   ADC threshold presented to the trigger unit
//   level_valid  trig_level holds an unaccepted value
//   level_ready  trigger unit accepts trig_level
module trig_level_cursor #(
    parameter int ROW_RESET    = 64,
    parameter int ROW_MAX      = 255,
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 1250000,
    parameter int CNT_W        = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  shift,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [7:0]  scan_row,
    input  logic        scan_active,
    output logic [7:0]  cursor_row,
    output logic        cursor_pix,
    output logic [13:0] trig_level,
    output logic        level_valid,
    input  logic        level_ready
);

    localparam logic [7:0]       ROW_RST_V = 8'(ROW_RESET);
    localparam logic [7:0]       ROW_MAX_V = 8'(ROW_MAX);
    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD   = CNT_W'(REPEAT_RATE - 1);
    localparam logic [13:0]      LEVEL_MAX = 14'h3FFF;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;

    // Screen-row offset that undoes the forward scaler's centring.
    function automatic logic signed [9:0] row_offset(input logic [1:0] sh);
        case (sh)
            2'd0:    return 10'sd4;
            2'd1:    return -10'sd28;
            2'd2:    return -10'sd44;
            default: return -10'sd52;
        endcase
    endfunction

    // Scale back to the ADC domain and clamp to the 14-bit range.
    function automatic logic [13:0] sat_level(input logic signed [9:0] d,
                                              input logic [1:0]        sh);
        logic signed [20:0] w;
        w = 21'(d);
        w = w <<< (5'd7 + 5'(sh));
`ifdef TRIG_MIDBIN_EN
        w = w + (21'sd1 <<< (5'd6 + 5'(sh)));
`else
        w = w + 21'sd0;
`endif
        if (d < 0)
            return 14'd0;
        else if (w > 21'sd16383)
            return LEVEL_MAX;
        else
            return w[13:0];
    endfunction

    // One clamped step; at a limit the row simply stays put.
    function automatic logic [7:0] step_row(input logic [7:0] row, input logic up);
        if (up)
            return (row < ROW_MAX_V) ? row + 8'd1 : row;
        else
            return (row > 8'd0) ? row - 8'd1 : row;
    endfunction

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             one_btn;

    logic [1:0]        shift_p0;
    logic signed [9:0] d_p1;
    logic [1:0]        shift_p1;
    logic              vld_p1;
    logic [13:0]       level_p2;
    logic [1:0]        shift_p2;
    logic              vld_p2;
    logic [1:0]        shift_out;
    logic              has_new;

    assign one_btn = btn_up ^ btn_down;

    // Button FSM: step on press, wait REPEAT_DELAY, then step every
    // REPEAT_RATE. Release or both buttons abort without stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cursor_row <= ROW_RST_V;
        end else begin
            case (state)
                IDLE: begin
                    if (one_btn) begin
                        cursor_row <= step_row(cursor_row, btn_up);
                        cnt        <= DELAY_LD;
                        state      <= DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!one_btn) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        cursor_row <= step_row(cursor_row, btn_up);
                        cnt        <= RATE_LD;
                        state      <= REPEAT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_p0 <= 2'd0;
            d_p1     <= '0;
            shift_p1 <= 2'd0;
            vld_p1   <= 1'b0;
            level_p2 <= 14'd0;
            shift_p2 <= 2'd0;
            vld_p2   <= 1'b0;
        end else begin
            // p0: shift registered alongside cursor_row
            shift_p0 <= shift;
            // p1: signed row offset
            d_p1     <= $signed({2'b00, cursor_row}) + row_offset(shift_p0);
            shift_p1 <= shift_p0;
            vld_p1   <= 1'b1;
            // p2: scale and saturate
            level_p2 <= sat_level(d_p1, shift_p1);
            shift_p2 <= shift_p1;
            vld_p2   <= vld_p1;
        end
    end

    // The pending copy is level_p2 itself (latest wins); it is pending when
    // it differs from what the output register last took, in value or scale.
    assign has_new = vld_p2 && ((level_p2 != trig_level) || (shift_p2 != shift_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_level  <= 14'd0;
            shift_out   <= 2'd0;
            level_valid <= 1'b0;
        end else if (!(level_valid && !level_ready)) begin
            if (has_new) begin
                trig_level  <= level_p2;
                shift_out   <= shift_p2;
                level_valid <= 1'b1;
            end else begin
                level_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cursor_pix <= 1'b0;
        else
            cursor_pix <= scan_active && (scan_row == cursor_row);
    end

endmodule

// File: tb/tb_trig_level_cursor.sv
// tb_trig_level_cursor
//   Directed bench for trig_level_cursor with short repeat timing
//   (REPEAT_DELAY = 10, REPEAT_RATE = 3). Each task drives one scenario and
//   checks the outputs against hand-computed values.
module tb_trig_level_cursor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  shift;
    logic        btn_up;
    logic        btn_down;
    logic [7:0]  scan_row;
    logic        scan_active;
    logic [7:0]  cursor_row;
    logic        cursor_pix;
    logic [13:0] trig_level;
    logic        level_valid;
    logic        level_ready;

    int n_tests = 0;
    int n_fail  = 0;

    trig_level_cursor #(
        .ROW_RESET   (64),
        .ROW_MAX     (255),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (3),
        .CNT_W       (24)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift      (shift),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .scan_row   (scan_row),
        .scan_active(scan_active),
        .cursor_row (cursor_row),
        .cursor_pix (cursor_pix),
        .trig_level (trig_level),
        .level_valid(level_valid),
        .level_ready(level_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // n single presses, each one cycle held and one cycle released
    task automatic press(input logic up, input int n);
        for (int i = 0; i < n; i++) begin
            btn_up   = up;
            btn_down = !up;
            tick();
            btn_up   = 1'b0;
            btn_down = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst_n       = 1'b0;
        level_ready = rdy;
        shift       = 2'd0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        scan_row    = 8'd0;
        scan_active = 1'b0;
        tick_n(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        level_ready = 1'b1;
        shift       = 2'd0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        scan_row    = 8'd0;
        scan_active = 1'b0;
        tick_n(2);
        n_tests++; if (cursor_row !== 8'd64) begin n_fail++; $display("FAIL reset_row: got %0d want 64", cursor_row); end
        n_tests++; if (cursor_pix !== 1'b0) begin n_fail++; $display("FAIL reset_pix: got %0b want 0", cursor_pix); end
        n_tests++; if (trig_level !== 14'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", trig_level); end
        n_tests++; if (level_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", level_valid); end
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (level_valid !== (c == 3)) begin
                n_fail++; $display("FAIL reset_pulse c%0d: got %0b want %0b", c, level_valid, (c == 3));
            end
            if (c == 3) begin
                n_tests++; if (trig_level !== 14'd8704) begin n_fail++; $display("FAIL reset_first_level: got %0d want 8704", trig_level); end
            end
        end
    endtask

    task automatic test_shift();
        shift = 2'd1;
        tick_n(3);
        n_tests++; if (level_valid !== 1'b0) begin n_fail++; $display("FAIL shift_latency: got %0b want 0", level_valid); end
        tick();
        n_tests++; if (level_valid !== 1'b1) begin n_fail++; $display("FAIL shift_valid: got %0b want 1", level_valid); end
        n_tests++; if (trig_level !== 14'd9216) begin n_fail++; $display("FAIL shift1_row64: got %0d want 9216", trig_level); end
        tick();
        n_tests++; if (level_valid !== 1'b0) begin n_fail++; $display("FAIL shift_drop: got %0b want 0", level_valid); end
        press(1'b0, 4);
        shift = 2'd3;
        tick_n(6);
        n_tests++; if (cursor_row !== 8'd60) begin n_fail++; $display("FAIL shift3_row: got %0d want 60", cursor_row); end
        n_tests++; if (trig_level !== 14'd8192) begin n_fail++; $display("FAIL shift3_row60: got %0d want 8192", trig_level); end
    endtask

    task automatic test_saturation();
        press(1'b0, 40);
        shift = 2'd1;
        tick_n(6);
        n_tests++; if (cursor_row !== 8'd20) begin n_fail++; $display("FAIL sat_low_row: got %0d want 20", cursor_row); end
        n_tests++; if (trig_level !== 14'd0) begin n_fail++; $display("FAIL sat_low_level: got %0d want 0", trig_level); end
        press(1'b1, 180);
        shift = 2'd0;
        tick_n(6);
        n_tests++; if (cursor_row !== 8'd200) begin n_fail++; $display("FAIL sat_high_row: got %0d want 200", cursor_row); end
        n_tests++; if (trig_level !== 14'd16383) begin n_fail++; $display("FAIL sat_high_level: got %0d want 16383", trig_level); end
        press(1'b1, 55);
        tick_n(6);
        n_tests++; if (cursor_row !== 8'd255) begin n_fail++; $display("FAIL clamp_reach: got %0d want 255", cursor_row); end
        btn_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++; if (cursor_row !== 8'd255) begin n_fail++; $display("FAIL clamp_row i%0d: got %0d want 255", i, cursor_row); end
            n_tests++; if (level_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_valid i%0d: got %0b want 0", i, level_valid); end
        end
        btn_up = 1'b0;
        tick();
    endtask

    task automatic test_autorepeat();
        int exp_row [20] = '{65, 65, 65, 65, 65, 65, 65, 65, 65, 65,
                             66, 66, 66, 67, 67, 67, 68, 68, 68, 69};
        do_reset(1'b1);
        tick_n(5);
        btn_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if (cursor_row !== 8'(exp_row[i])) begin
                n_fail++; $display("FAIL repeat_row i%0d: got %0d want %0d", i, cursor_row, exp_row[i]);
            end
        end
        btn_up = 1'b0;
        tick();
        n_tests++; if (cursor_row !== 8'd69) begin n_fail++; $display("FAIL repeat_release: got %0d want 69", cursor_row); end
        btn_up   = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_tests++; if (cursor_row !== 8'd69) begin n_fail++; $display("FAIL both_held i%0d: got %0d want 69", i, cursor_row); end
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        tick_n(3);
        n_tests++; if (level_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %0b want 1", level_valid); end
        n_tests++; if (trig_level !== 14'd8704) begin n_fail++; $display("FAIL bp_first_level: got %0d want 8704", trig_level); end
        press(1'b1, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (trig_level !== 14'd8704) begin n_fail++; $display("FAIL bp_frozen i%0d: got %0d want 8704", i, trig_level); end
        end
        n_tests++; if (cursor_row !== 8'd66) begin n_fail++; $display("FAIL bp_row: got %0d want 66", cursor_row); end
        n_tests++; if (level_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %0b want 1", level_valid); end
        level_ready = 1'b1;
        tick();
        n_tests++; if (level_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %0b want 1", level_valid); end
        n_tests++; if (trig_level !== 14'd8960) begin n_fail++; $display("FAIL bp_latest_level: got %0d want 8960", trig_level); end
        tick();
        n_tests++; if (level_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b want 0", level_valid); end
    endtask

    task automatic test_cursor_pix();
        scan_row    = cursor_row;
        scan_active = 1'b1;
        tick();
        n_tests++; if (cursor_pix !== 1'b1) begin n_fail++; $display("FAIL pix_on: got %0b want 1", cursor_pix); end
        scan_active = 1'b0;
        tick();
        n_tests++; if (cursor_pix !== 1'b0) begin n_fail++; $display("FAIL pix_inactive: got %0b want 0", cursor_pix); end
        scan_active = 1'b1;
        scan_row    = cursor_row + 8'd1;
        tick();
        n_tests++; if (cursor_pix !== 1'b0) begin n_fail++; $display("FAIL pix_other_row: got %0b want 0", cursor_pix); end
        scan_active = 1'b0;
    endtask

    task automatic test_reset_midbp();
        level_ready = 1'b0;
        press(1'b1, 1);
        tick_n(3);
        n_tests++; if (level_valid !== 1'b1) begin n_fail++; $display("FAIL midbp_valid: got %0b want 1", level_valid); end
        n_tests++; if (trig_level !== 14'd9088) begin n_fail++; $display("FAIL midbp_level: got %0d want 9088", trig_level); end
        rst_n = 1'b0;
        #2;
        n_tests++; if (level_valid !== 1'b0) begin n_fail++; $display("FAIL midbp_reset_valid: got %0b want 0", level_valid); end
        n_tests++; if (cursor_row !== 8'd64) begin n_fail++; $display("FAIL midbp_reset_row: got %0d want 64", cursor_row); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_shift();
        test_saturation();
        test_autorepeat();
        test_backpressure();
        test_cursor_pix();
        test_reset_midbp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
